// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter
//   Shares the single register-file write port between the in-order WB stage
//   and an out-of-band multi-cycle unit (MDU). Pipeline writes win the port;
//   MDU results wait in a small FIFO and drain through idle WB slots. If queued
//   results lose arbitration STARVE_LIMIT times in a row, a one-cycle pipeline
//   freeze (pipe_stall) is raised so the FIFO head gets the port.
//
// Ports
//   clk, rst                    clock, synchronous active-high reset
//   wb_reg_write/wb_mem_to_reg  WB-stage write enable and data select
//   wb_write_reg                WB-stage destination register
//   wb_mem_data/wb_alu_result   WB-stage candidate write data
//   mdu_valid/mdu_ready         MDU result handshake (ready = FIFO not full)
//   mdu_reg/mdu_data            MDU destination register and result
//   rf_we/rf_waddr/rf_wdata     register-file write port (combinational)
//   pipe_stall                  registered one-cycle freeze of MEM/WB and earlier
//   busy_mask                   one bit per register targeted by a queued result
module wb_port_arbiter #(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_reg_write,
  input  logic        wb_mem_to_reg,
  input  logic [4:0]  wb_write_reg,
  input  logic [31:0] wb_mem_data,
  input  logic [31:0] wb_alu_result,
  input  logic        mdu_valid,
  output logic        mdu_ready,
  input  logic [4:0]  mdu_reg,
  input  logic [31:0] mdu_data,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        pipe_stall,
  output logic [31:0] busy_mask
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;
  logic [SW-1:0] r_starve;
  logic          r_pipe_stall;
  logic [4:0]    r_mem_reg  [DEPTH];
  logic [31:0]   r_mem_data [DEPTH];

  logic          w_empty;
  logic          w_full;
  logic          w_pipe_req;
  logic          w_pop;
  logic          w_push;
  logic [31:0]   w_busy;

  assign w_empty    = (r_count == '0);
  assign w_full     = (r_count == CW'(DEPTH));
  // A held WB instruction is ignored while frozen; it retires the next cycle.
  assign w_pipe_req = wb_reg_write && (wb_write_reg != 5'd0) && !r_pipe_stall;
  assign w_pop      = !w_pipe_req && !w_empty;
  // Results for $0 complete the handshake but are dropped.
  assign w_push     = mdu_valid && !w_full && (mdu_reg != 5'd0);

  assign mdu_ready  = !w_full;
  assign pipe_stall = r_pipe_stall;
  assign busy_mask  = w_busy;

  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = 5'd0;
    rf_wdata = 32'd0;
    if (w_pipe_req) begin
      rf_we    = 1'b1;
      rf_waddr = wb_write_reg;
      rf_wdata = wb_mem_to_reg ? wb_mem_data : wb_alu_result;
    end else if (!w_empty) begin
      rf_we    = 1'b1;
      rf_waddr = r_mem_reg[r_rd_ptr];
      rf_wdata = r_mem_data[r_rd_ptr];
    end
  end

  // Walk entries from the head; only the first r_count slots are live.
  always_comb begin
    w_busy = 32'd0;
    for (int i = 0; i < DEPTH; i++) begin
      if (CW'(i) < r_count) begin
        w_busy[r_mem_reg[r_rd_ptr + PW'(i)]] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_ptr     <= '0;
      r_wr_ptr     <= '0;
      r_count      <= '0;
      r_starve     <= '0;
      r_pipe_stall <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase

      // The stall is raised on the same edge the counter hits the limit, so
      // exactly STARVE_LIMIT losses precede the freeze. It needs a pipeline
      // win to fire, which is impossible while frozen, so it never repeats.
      r_pipe_stall <= 1'b0;
      if (w_pop || w_empty) begin
        r_starve <= '0;
      end else if (w_pipe_req) begin
        if (r_starve == SW'(STARVE_LIMIT - 1)) begin
          r_starve     <= '0;
          r_pipe_stall <= 1'b1;
        end else begin
          r_starve <= r_starve + 1'b1;
        end
      end
    end
  end

  // FIFO storage carries no reset; liveness comes from r_count alone.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_reg[r_wr_ptr]  <= mdu_reg;
      r_mem_data[r_wr_ptr] <= mdu_data;
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter (DEPTH=2, STARVE_LIMIT=4).
// Inputs change 1 time unit after each rising edge; outputs are checked one
// further time unit later, well away from the next edge.
module tb_wb_port_arbiter;

  logic        clk;
  logic        rst;
  logic        wb_reg_write;
  logic        wb_mem_to_reg;
  logic [4:0]  wb_write_reg;
  logic [31:0] wb_mem_data;
  logic [31:0] wb_alu_result;
  logic        mdu_valid;
  logic        mdu_ready;
  logic [4:0]  mdu_reg;
  logic [31:0] mdu_data;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        pipe_stall;
  logic [31:0] busy_mask;

  int errors = 0;
  int checks = 0;

  wb_port_arbiter #(.DEPTH(2), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .wb_reg_write(wb_reg_write), .wb_mem_to_reg(wb_mem_to_reg),
    .wb_write_reg(wb_write_reg), .wb_mem_data(wb_mem_data),
    .wb_alu_result(wb_alu_result),
    .mdu_valid(mdu_valid), .mdu_ready(mdu_ready),
    .mdu_reg(mdu_reg), .mdu_data(mdu_data),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .pipe_stall(pipe_stall), .busy_mask(busy_mask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // Check the whole write port in one call.
  task automatic chk_port(input string tag, input logic we, input logic [4:0] a, input logic [31:0] d);
    chk({tag, ".we"},   32'(rf_we), 32'(we));
    chk({tag, ".addr"}, 32'(rf_waddr), 32'(a));
    chk({tag, ".data"}, rf_wdata, d);
  endtask

  initial begin
    rst = 1'b1;
    wb_reg_write = 1'b0; wb_mem_to_reg = 1'b0; wb_write_reg = 5'd0;
    wb_mem_data = 32'd0; wb_alu_result = 32'd0;
    mdu_valid = 1'b0; mdu_reg = 5'd0; mdu_data = 32'd0;
    tick(); tick();
    rst = 1'b0;
    settle();

    // Reset state
    chk("rst.ready", 32'(mdu_ready), 32'd1);
    chk("rst.busy",  busy_mask, 32'd0);
    chk("rst.stall", 32'(pipe_stall), 32'd0);
    chk_port("rst.port", 1'b0, 5'd0, 32'd0);

    // Idle pipe, MDU result r5 = 0x1234 appears one cycle later
    mdu_valid = 1'b1; mdu_reg = 5'd5; mdu_data = 32'h1234;
    settle();
    chk("t1.ready", 32'(mdu_ready), 32'd1);
    chk_port("t1.nobypass", 1'b0, 5'd0, 32'd0);
    tick();
    mdu_valid = 1'b0; settle();
    chk_port("t1.drain", 1'b1, 5'd5, 32'h1234);
    chk("t1.busy", busy_mask, 32'h0000_0020);
    tick(); settle();
    chk("t1.busy_clr", busy_mask, 32'd0);
    chk("t1.idle_we", 32'(rf_we), 32'd0);

    // Data select and $0 suppression on the pipeline side
    wb_reg_write = 1'b1; wb_write_reg = 5'd9; wb_mem_to_reg = 1'b1;
    wb_mem_data = 32'hAAAA; wb_alu_result = 32'h5555;
    settle();
    chk_port("t2.mem", 1'b1, 5'd9, 32'hAAAA);
    wb_mem_to_reg = 1'b0; settle();
    chk_port("t2.alu", 1'b1, 5'd9, 32'h5555);
    wb_write_reg = 5'd0; settle();
    chk_port("t2.r0", 1'b0, 5'd0, 32'd0);
    wb_reg_write = 1'b0;

    // MDU result to r0: accepted, never queued
    tick();
    mdu_valid = 1'b1; mdu_reg = 5'd0; mdu_data = 32'hDEAD; settle();
    chk("t3.ready", 32'(mdu_ready), 32'd1);
    tick();
    mdu_valid = 1'b0; settle();
    chk_port("t3.port", 1'b0, 5'd0, 32'd0);
    chk("t3.busy", busy_mask, 32'd0);
    tick(); settle();
    chk("t3.we_later", 32'(rf_we), 32'd0);

    // Starvation: r3 every cycle, one r7 result -> 4 losses, 1 stall cycle
    wb_reg_write = 1'b1; wb_write_reg = 5'd3; wb_alu_result = 32'h33;
    mdu_valid = 1'b1; mdu_reg = 5'd7; mdu_data = 32'h77; settle();
    chk_port("t4.c0", 1'b1, 5'd3, 32'h33);
    tick();
    mdu_valid = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      settle();
      chk($sformatf("t4.c%0d.addr", k), 32'(rf_waddr), 32'd3);
      chk($sformatf("t4.c%0d.stall", k), 32'(pipe_stall), 32'd0);
      chk($sformatf("t4.c%0d.busy", k), busy_mask, 32'h0000_0080);
      tick();
    end
    settle();
    chk("t4.stall", 32'(pipe_stall), 32'd1);
    chk_port("t4.r7", 1'b1, 5'd7, 32'h77);
    tick(); settle();
    chk("t4.unstall", 32'(pipe_stall), 32'd0);
    chk_port("t4.resume", 1'b1, 5'd3, 32'h33);
    chk("t4.busy_clr", busy_mask, 32'd0);

    // Fill the FIFO under continuous pipe writes; third offer must wait
    tick();
    mdu_valid = 1'b1; mdu_reg = 5'd10; mdu_data = 32'hA0; settle();
    chk("t5.rdy0", 32'(mdu_ready), 32'd1);
    tick();
    mdu_reg = 5'd11; mdu_data = 32'hB0; settle();
    chk("t5.rdy1", 32'(mdu_ready), 32'd1);
    tick();
    mdu_reg = 5'd12; mdu_data = 32'hC0; settle();
    chk("t5.full", 32'(mdu_ready), 32'd0);
    chk("t5.busy2", busy_mask, 32'h0000_0C00);
    tick(); tick(); tick(); settle();
    chk("t5.stall", 32'(pipe_stall), 32'd1);
    chk("t5.stall_rdy", 32'(mdu_ready), 32'd0);
    chk_port("t5.head", 1'b1, 5'd10, 32'hA0);
    tick(); settle();
    chk("t5.rdy_after", 32'(mdu_ready), 32'd1);
    chk_port("t5.pipe", 1'b1, 5'd3, 32'h33);
    chk("t5.busy1", busy_mask, 32'h0000_0800);
    tick();
    mdu_valid = 1'b0; wb_reg_write = 1'b0; settle();
    chk("t5.busy_b", busy_mask, 32'h0000_1800);
    chk_port("t5.r11", 1'b1, 5'd11, 32'hB0);
    tick(); settle();
    chk_port("t5.r12", 1'b1, 5'd12, 32'hC0);
    tick(); settle();
    chk("t5.empty_we", 32'(rf_we), 32'd0);
    chk("t5.empty_busy", busy_mask, 32'd0);

    // Reset with two queued entries
    wb_reg_write = 1'b1; wb_write_reg = 5'd3;
    mdu_valid = 1'b1; mdu_reg = 5'd20; mdu_data = 32'h20;
    tick();
    mdu_reg = 5'd21; mdu_data = 32'h21;
    tick();
    mdu_valid = 1'b0; settle();
    chk("t6.busy_pre", busy_mask, 32'h0030_0000);
    chk("t6.rdy_pre", 32'(mdu_ready), 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0; wb_reg_write = 1'b0; settle();
    chk("t6.busy", busy_mask, 32'd0);
    chk("t6.ready", 32'(mdu_ready), 32'd1);
    chk("t6.stall", 32'(pipe_stall), 32'd0);
    chk("t6.we", 32'(rf_we), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
